// File: rtl/query_requester.sv
// Initiator end of the query protocol: accepts core queries into NSLOT slots, issues
// request packets into the requestor NoC and matches responses back by reg_id.
// Optional feature macro: QREQ_RETRY_EN. When it is defined, timed-out queries are
// re-issued up to MAX_RETRY times before being abandoned. When it is undefined, a
// timeout abandons the query at once.
module query_requester #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RESP_W  = 25,
  parameter int unsigned REQ_W   = 12,
  parameter int unsigned NSLOT   = 4,
  parameter int unsigned TIMEOUT = 255
`ifdef QREQ_RETRY_EN
  ,
  parameter int unsigned MAX_RETRY = 2
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        id,
  input  logic              q_valid,
  input  logic [5:0]        q_reg_id,
  input  logic [1:0]        q_target,
  output logic              q_ready,
  output logic [REQ_W-1:0]  req_out,
  output logic              req_write,
  input  logic              req_full,
  input  logic              req_almost_full,
  input  logic [RESP_W-1:0] resp_in,
  output logic              res_valid,
  output logic [5:0]        res_reg_id,
  output logic [DATA_W-1:0] res_data,
  output logic              stray,
  output logic              err
);

  typedef enum logic [1:0] {StFree, StPend, StWait} slot_st_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  slot_st_e   state_q [NSLOT];
  slot_st_e   state_d [NSLOT];
  logic [5:0] reg_q   [NSLOT];
  logic [5:0] reg_d   [NSLOT];
  logic [1:0] tgt_q   [NSLOT];
  logic [1:0] tgt_d   [NSLOT];
  logic [7:0] timer_q [NSLOT];
  logic [7:0] timer_d [NSLOT];
`ifdef QREQ_RETRY_EN
  logic [1:0] retry_q [NSLOT];
  logic [1:0] retry_d [NSLOT];
`endif

  logic [NSLOT-1:0] accept_sel;
  logic [NSLOT-1:0] issue_sel;
  logic [NSLOT-1:0] match;
  logic             any_free;
  logic             dup;
  logic             accept;
  logic             issue_ok;
  logic [REQ_W-1:0] req_pkt;
  logic             timeout_err;

  logic              resp_v;
  logic [1:0]        resp_dest;
  logic [5:0]        resp_reg;
  logic [DATA_W-1:0] resp_data;

  assign resp_v    = resp_in[0];
  assign resp_dest = resp_in[2:1];
  assign resp_reg  = resp_in[8:3];
  assign resp_data = resp_in[DATA_W+8:9];

  // Throttle on NoC fullness: almost_full matters when a write is already in flight.
  assign issue_ok = !((req_write & req_almost_full) | (~req_write & req_full));

  // Slot selection: lowest FREE slot for accept, lowest PEND slot for issue, response match.
  always_comb begin
    any_free   = 1'b0;
    dup        = 1'b0;
    accept_sel = '0;
    issue_sel  = '0;
    match      = '0;
    req_pkt    = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (state_q[i] == StFree) begin
        if (!any_free) accept_sel[i] = 1'b1;
        any_free = 1'b1;
      end else if (reg_q[i] == q_reg_id) begin
        dup = 1'b1;
      end
      if (state_q[i] == StPend && issue_sel == '0) issue_sel[i] = 1'b1;
      match[i] = resp_v && (resp_dest == id) && (state_q[i] == StWait) &&
                 (reg_q[i] == resp_reg);
    end
    q_ready = reset & any_free & ~dup;
    accept  = q_valid & q_ready;
    if (!accept) accept_sel = '0;
    if (!issue_ok) issue_sel = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (issue_sel[i]) req_pkt = REQ_W'({1'b0, reg_q[i], id, tgt_q[i], 1'b1});
    end
  end

  // Per-slot next state: accept, issue, response match (wins over timeout), timer/timeout.
  always_comb begin
    timeout_err = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      state_d[i] = state_q[i];
      reg_d[i]   = reg_q[i];
      tgt_d[i]   = tgt_q[i];
      timer_d[i] = timer_q[i];
`ifdef QREQ_RETRY_EN
      retry_d[i] = retry_q[i];
`endif
      unique case (state_q[i])
        StFree: begin
          if (accept_sel[i]) begin
            state_d[i] = StPend;
            reg_d[i]   = q_reg_id;
            tgt_d[i]   = q_target;
`ifdef QREQ_RETRY_EN
            retry_d[i] = 2'd0;
`endif
          end
        end
        StPend: begin
          if (issue_sel[i]) begin
            state_d[i] = StWait;
            timer_d[i] = 8'd0;
          end
        end
        StWait: begin
          if (match[i]) begin
            state_d[i] = StFree;
          end else if (timer_q[i] == TimeoutVal) begin
`ifdef QREQ_RETRY_EN
            if (32'(retry_q[i]) < MAX_RETRY) begin
              retry_d[i] = retry_q[i] + 2'd1;
              state_d[i] = StPend;
            end else begin
              state_d[i]  = StFree;
              timeout_err = 1'b1;
            end
`else
            state_d[i]  = StFree;
            timeout_err = 1'b1;
`endif
          end else begin
            timer_d[i] = timer_q[i] + 8'd1;
          end
        end
        default: state_d[i] = StFree;
      endcase
    end
  end

  // Slot state registers; reset discards every outstanding query.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= StFree;
        reg_q[i]   <= 6'd0;
        tgt_q[i]   <= 2'd0;
        timer_q[i] <= 8'd0;
`ifdef QREQ_RETRY_EN
        retry_q[i] <= 2'd0;
`endif
      end
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= state_d[i];
        reg_q[i]   <= reg_d[i];
        tgt_q[i]   <= tgt_d[i];
        timer_q[i] <= timer_d[i];
`ifdef QREQ_RETRY_EN
        retry_q[i] <= retry_d[i];
`endif
      end
    end
  end

  // Registered outputs: request strobe/packet, result, stray and err pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_out    <= '0;
      req_write  <= 1'b0;
      res_valid  <= 1'b0;
      res_reg_id <= 6'd0;
      res_data   <= '0;
      stray      <= 1'b0;
      err        <= 1'b0;
    end else begin
      req_write <= |issue_sel;
      if (|issue_sel) req_out <= req_pkt;
      res_valid <= |match;
      if (|match) begin
        res_reg_id <= resp_reg;
        res_data   <= resp_data;
      end
      stray <= resp_v & ~(|match);
      err   <= timeout_err;
    end
  end

endmodule

// File: tb/tb_query_requester.sv
// Directed self-checking bench for query_requester (TIMEOUT=8, own port id=1).
module tb_query_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  id;
  logic        q_valid;
  logic [5:0]  q_reg_id;
  logic [1:0]  q_target;
  logic        q_ready;
  logic [11:0] req_out;
  logic        req_write;
  logic        req_full;
  logic        req_almost_full;
  logic [24:0] resp_in;
  logic        res_valid;
  logic [5:0]  res_reg_id;
  logic [15:0] res_data;
  logic        stray;
  logic        err;

  always #5 clk = ~clk;

  query_requester #(.TIMEOUT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .id              (id),
    .q_valid         (q_valid),
    .q_reg_id        (q_reg_id),
    .q_target        (q_target),
    .q_ready         (q_ready),
    .req_out         (req_out),
    .req_write       (req_write),
    .req_full        (req_full),
    .req_almost_full (req_almost_full),
    .resp_in         (resp_in),
    .res_valid       (res_valid),
    .res_reg_id      (res_reg_id),
    .res_data        (res_data),
    .stray           (stray),
    .err             (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected request packet for own port 1.
  function automatic logic [31:0] qpkt(input logic [5:0] r, input logic [1:0] t);
    return 32'({1'b0, r, 2'b01, t, 1'b1});
  endfunction

  task automatic apply_reset();
    reset = 1'b0; q_valid = 1'b0; resp_in = '0; req_full = 1'b0; req_almost_full = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic query(input logic [5:0] r, input logic [1:0] t);
    q_valid = 1'b1; q_reg_id = r; q_target = t;
    #1;
    check("q_ready_on_accept", 32'(q_ready), 32'd1);
    tick();
    q_valid = 1'b0;
  endtask

  task automatic respond(input logic [15:0] d, input logic [5:0] r, input logic [1:0] dst);
    resp_in = {d, r, dst, 1'b1};
    tick();
    resp_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int issues;
    logic seen;
    reset = 1'b0; id = 2'b01; q_valid = 1'b0; q_reg_id = '0; q_target = '0;
    req_full = 1'b0; req_almost_full = 1'b0; resp_in = '0;

    // Reset state
    tick();
    tick();
    q_valid = 1'b1; q_reg_id = 6'h01;
    #1;
    check("rst_q_ready", 32'(q_ready), 32'd0);
    check("rst_req_write", 32'(req_write), 32'd0);
    check("rst_req_out", 32'(req_out), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_stray", 32'(stray), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    q_valid = 1'b0;
    reset = 1'b1;
    tick();

    // 1: basic query, 2-cycle issue latency, matched response
    query(6'h2A, 2'b11);
    check("t1_no_issue_at_accept", 32'(req_write), 32'd0);
    tick();
    check("t1_req_write", 32'(req_write), 32'd1);
    check("t1_req_out", 32'(req_out), 32'h54F);
    tick();
    check("t1_req_write_pulse", 32'(req_write), 32'd0);
    respond(16'hBEEF, 6'h2A, 2'b01);
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_res_reg_id", 32'(res_reg_id), 32'h2A);
    check("t1_res_data", 32'(res_data), 32'hBEEF);
    check("t1_no_stray", 32'(stray), 32'd0);
    tick();
    check("t1_res_valid_pulse", 32'(res_valid), 32'd0);

    // 2: fill all slots (held PEND), stall, drain, duplicate stall
    apply_reset();
    req_full = 1'b1;
    for (int r = 1; r <= 4; r++) query(6'(r), 2'b10);
    q_valid = 1'b1; q_reg_id = 6'h05; q_target = 2'b10;
    #1;
    check("t2_full_stall", 32'(q_ready), 32'd0);
    check("t2_blocked_issue", 32'(req_write), 32'd0);
    q_valid = 1'b0;
    req_full = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      tick();
      check("t2_issue_write", 32'(req_write), 32'd1);
      check("t2_issue_order", 32'(req_out), qpkt(6'(r), 2'b10));
    end
    tick();
    check("t2_issue_done", 32'(req_write), 32'd0);
    respond(16'h1234, 6'h03, 2'b01);
    check("t2_res_valid", 32'(res_valid), 32'd1);
    check("t2_res_data", 32'(res_data), 32'h1234);
    q_valid = 1'b1; q_reg_id = 6'h04;
    #1;
    check("t2_dup_stall", 32'(q_ready), 32'd0);
    q_reg_id = 6'h05;
    #1;
    check("t2_slot_freed", 32'(q_ready), 32'd1);
    q_valid = 1'b0;

    // 3: full / almost_full throttling, lowest index first
    apply_reset();
    req_full = 1'b1;
    query(6'h10, 2'b00);
    query(6'h11, 2'b00);
    query(6'h12, 2'b00);
    tick();
    check("t3_full_hold", 32'(req_write), 32'd0);
    req_full = 1'b0; req_almost_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_issue", 32'(req_write), 32'd1);
      check("t3_issue_pkt", 32'(req_out), qpkt(6'(6'h10 + k), 2'b00));
      tick();
      check("t3_af_withheld", 32'(req_write), 32'd0);
    end
    req_almost_full = 1'b0;

    // 4: stray responses leave slots untouched
    apply_reset();
    req_full = 1'b1;
    query(6'h07, 2'b01);
    respond(16'hAAAA, 6'h07, 2'b01);
    check("t4_pend_only_stray", 32'(stray), 32'd1);
    check("t4_pend_only_nores", 32'(res_valid), 32'd0);
    req_full = 1'b0;
    tick();
    check("t4_issue", 32'(req_write), 32'd1);
    respond(16'h5555, 6'h07, 2'b10);
    check("t4_wrong_port_stray", 32'(stray), 32'd1);
    check("t4_wrong_port_nores", 32'(res_valid), 32'd0);
    respond(16'h5555, 6'h08, 2'b01);
    check("t4_unknown_stray", 32'(stray), 32'd1);
    respond(16'hC0DE, 6'h07, 2'b01);
    check("t4_res_valid", 32'(res_valid), 32'd1);
    check("t4_res_data", 32'(res_data), 32'hC0DE);
    check("t4_no_stray", 32'(stray), 32'd0);

    // 5a: timeout without response
    apply_reset();
    query(6'h15, 2'b11);
    tick();
    check("t5_issue", 32'(req_write), 32'd1);
    n = 0; issues = 1; seen = 1'b0;
    while (!err && n < 60) begin
      tick();
      n++;
      if (req_write) issues++;
      if (res_valid) seen = 1'b1;
    end
`ifdef QREQ_RETRY_EN
    check("t5_err_latency", 32'(n), 32'd29);
    check("t5_issue_count", 32'(issues), 32'd3);
`else
    check("t5_err_latency", 32'(n), 32'd9);
    check("t5_issue_count", 32'(issues), 32'd1);
`endif
    check("t5_no_result", 32'(seen), 32'd0);
    tick();
    check("t5_err_pulse", 32'(err), 32'd0);

    // 5b: response on the exact timeout cycle wins
    apply_reset();
    query(6'h16, 2'b11);
    tick();
    check("t5b_issue", 32'(req_write), 32'd1);
    repeat (8) tick();
    respond(16'hF00D, 6'h16, 2'b01);
    check("t5b_res_valid", 32'(res_valid), 32'd1);
    check("t5b_res_data", 32'(res_data), 32'hF00D);
    check("t5b_no_err", 32'(err), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (err || req_write) seen = 1'b1;
    end
    check("t5b_quiet_after", 32'(seen), 32'd0);

    // 6: reset mid-operation discards waiting queries
    apply_reset();
    query(6'h30, 2'b00);
    query(6'h31, 2'b00);
    query(6'h32, 2'b00);
    tick();
    check("t6_last_issue", 32'(req_write), 32'd1);
    reset = 1'b0;
    q_valid = 1'b1; q_reg_id = 6'h33;
    tick();
    check("t6_rst_q_ready", 32'(q_ready), 32'd0);
    check("t6_rst_req_write", 32'(req_write), 32'd0);
    tick();
    q_valid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      respond(16'h0BAD, 6'(6'h30 + k), 2'b01);
      check("t6_late_stray", 32'(stray), 32'd1);
      check("t6_late_nores", 32'(res_valid), 32'd0);
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (err || res_valid || req_write) seen = 1'b1;
    end
    check("t6_quiet_after", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
